// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute,
// memory and write-back steps and drives the datapath control lines.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        isZero,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWe,
  output logic        irWrite,
  output logic        pcWrite,
  output logic [1:0]  pcSrc,
  output logic        regWrite,
  output logic [1:0]  resultSrc,
  output logic [1:0]  aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [2:0]  immSel,
  output logic [3:0]  aluControl,
  output logic        trap,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR,
    BRANCH, JUMP, UPPER, TRAP
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  state_t      state;
  state_t      next_state;
  logic [31:0] instret_q;
  logic [3:0]  op_alu;
  logic        is_shift_imm;
  logic        taken;
  logic        unused_instr_bits;

  logic [6:0] opcode;
  logic [2:0] funct3;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Operand fields the controller never looks at (registers, immediates).
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Shift-immediate forms take their second operand from the shamt field.
  assign is_shift_imm = (opcode == OP_I) && (funct3 == 3'b001 || funct3 == 3'b101);

  // ALU operation for register/immediate arithmetic; SUB only exists for R-type.
  always_comb begin
    op_alu = ALU_ADD;
    case (funct3)
      3'b000:  op_alu = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  op_alu = ALU_SLL;
      3'b010:  op_alu = ALU_SLT;
      3'b011:  op_alu = ALU_SLTU;
      3'b100:  op_alu = ALU_XOR;
      3'b101:  op_alu = instr[30] ? ALU_SRA : ALU_SRL;
      3'b110:  op_alu = ALU_OR;
      default: op_alu = ALU_AND;
    endcase
  end

  // State register; reset always lands in FETCH, abandoning any access.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Retired-instruction counter, one tick per PC update, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset)        instret_q <= '0;
    else if (pcWrite) instret_q <= instret_q + 32'd1;
  end

  assign instret = reset ? '0 : instret_q;

  // Next-state and control outputs; everything idles at 0 unless the state drives it.
  always_comb begin
    next_state = state;
    memReq     = 1'b0;
    memWe      = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 2'd0;
    regWrite   = 1'b0;
    resultSrc  = 2'd0;
    aluSrcA    = 2'd0;
    aluSrcB    = 2'd0;
    immSel     = IMM_I;
    aluControl = ALU_ADD;
    trap       = 1'b0;
    taken      = 1'b0;
    case (state)
      FETCH: begin
        memReq = 1'b1;
        if (memReady) begin
          irWrite    = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          OP_R, OP_I:         next_state = EXEC;
          OP_LOAD, OP_STORE:  next_state = MEM_ADDR;
          OP_BR:              next_state = BRANCH;
          OP_JAL, OP_JALR:    next_state = JUMP;
          OP_LUI, OP_AUIPC:   next_state = UPPER;
          default:            next_state = TRAP;
        endcase
      end
      EXEC, WB_ALU: begin
        aluSrcA    = 2'd0;
        aluSrcB    = (opcode == OP_R) ? 2'd0 : (is_shift_imm ? 2'd2 : 2'd1);
        immSel     = IMM_I;
        aluControl = op_alu;
        if (state == WB_ALU) begin
          regWrite   = 1'b1;
          pcWrite    = 1'b1;
          next_state = FETCH;
        end else begin
          next_state = WB_ALU;
        end
      end
      MEM_ADDR: begin
        aluSrcB    = 2'd1;
        immSel     = (opcode == OP_STORE) ? IMM_S : IMM_I;
        next_state = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        memReq = 1'b1;
        if (memReady) next_state = WB_MEM;
      end
      WB_MEM: begin
        regWrite   = 1'b1;
        resultSrc  = 2'd1;
        pcWrite    = 1'b1;
        next_state = FETCH;
      end
      MEM_WR: begin
        memReq = 1'b1;
        memWe  = 1'b1;
        if (memReady) begin
          pcWrite    = 1'b1;
          next_state = FETCH;
        end
      end
      BRANCH: begin
        immSel     = IMM_B;
        next_state = FETCH;
        case (funct3)
          3'b000: begin aluControl = ALU_SUB;  taken = isZero;  end
          3'b001: begin aluControl = ALU_SUB;  taken = !isZero; end
          3'b100: begin aluControl = ALU_SLT;  taken = !isZero; end
          3'b101: begin aluControl = ALU_SLT;  taken = isZero;  end
          3'b110: begin aluControl = ALU_SLTU; taken = !isZero; end
          3'b111: begin aluControl = ALU_SLTU; taken = isZero;  end
          default: next_state = TRAP;
        endcase
        if (next_state != TRAP) begin
          pcWrite = 1'b1;
          pcSrc   = taken ? 2'd1 : 2'd0;
        end
      end
      JUMP: begin
        regWrite   = 1'b1;
        resultSrc  = 2'd2;
        pcWrite    = 1'b1;
        next_state = FETCH;
        if (opcode == OP_JAL) begin
          immSel = IMM_J;
          pcSrc  = 2'd1;
        end else begin
          aluSrcB = 2'd1;
          immSel  = IMM_I;
          pcSrc   = 2'd2;
        end
      end
      UPPER: begin
        immSel     = IMM_U;
        aluSrcB    = 2'd1;
        aluSrcA    = (opcode == OP_LUI) ? 2'd2 : 2'd1;
        regWrite   = 1'b1;
        pcWrite    = 1'b1;
        next_state = FETCH;
      end
      TRAP: begin
        trap = 1'b1;
      end
      default: next_state = FETCH;
    endcase
    if (reset) begin
      memReq     = 1'b0;
      memWe      = 1'b0;
      irWrite    = 1'b0;
      pcWrite    = 1'b0;
      pcSrc      = 2'd0;
      regWrite   = 1'b0;
      resultSrc  = 2'd0;
      aluSrcA    = 2'd0;
      aluSrcB    = 2'd0;
      immSel     = IMM_I;
      aluControl = ALU_ADD;
      trap       = 1'b0;
    end
  end

endmodule
